// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU types: flag bundle, sequential ALU opcodes, FSM states and Z policies.
package gb_cpu_common_pkg;

  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } alu_flags_t;

  typedef enum logic [3:0] {
    SeqOpAdd,
    SeqOpAdc,
    SeqOpSub,
    SeqOpSbc,
    SeqOpAnd,
    SeqOpOr,
    SeqOpXor,
    SeqOpCp,
    SeqOpInc,
    SeqOpDec
  } seq_alu_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } seq_alu_state_t;

  localparam logic [1:0] ZmodeCalc = 2'd0;
  localparam logic [1:0] ZmodeKeep = 2'd1;
  localparam logic [1:0] ZmodeZero = 2'd2;

  // Ops that run through the subtractor and set N.
  function automatic logic op_is_sub(input seq_alu_op_t op);
    return (op == SeqOpSub) || (op == SeqOpSbc) || (op == SeqOpCp) || (op == SeqOpDec);
  endfunction

endpackage

// File: rtl/gb_cpu_alu_slice.sv
// Combinational one-slice ALU: add/sub with carry/borrow chaining plus bitwise logic.
// cout_o/half_o are carries for add ops and borrows for subtract ops.
module gb_cpu_alu_slice
  import gb_cpu_common_pkg::*;
#(
  parameter int unsigned SLICE_W = 8
) (
  input  seq_alu_op_t        op_i,
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               cout_o,
  output logic               half_o
);

  logic               is_sub;
  logic [SLICE_W-1:0] b_eff;
  logic               c_eff;
  logic [SLICE_W:0]   full;
  logic [4:0]         nib;

  // Subtract is A + ~B + ~borrow_in; borrows are the inverted carries.
  assign is_sub = op_is_sub(op_i);
  assign b_eff  = is_sub ? ~b_i : b_i;
  assign c_eff  = is_sub ? ~cin_i : cin_i;
  assign full   = {1'b0, a_i} + {1'b0, b_eff} + (SLICE_W+1)'(c_eff);
  assign nib    = {1'b0, a_i[3:0]} + {1'b0, b_eff[3:0]} + 5'(c_eff);

  // Select arithmetic or logic result and the matching H/C contribution.
  always_comb begin
    sum_o  = full[SLICE_W-1:0];
    cout_o = full[SLICE_W] ^ is_sub;
    half_o = nib[4] ^ is_sub;
    case (op_i)
      SeqOpAnd: begin
        sum_o  = a_i & b_i;
        cout_o = 1'b0;
        half_o = 1'b1;
      end
      SeqOpOr: begin
        sum_o  = a_i | b_i;
        cout_o = 1'b0;
        half_o = 1'b0;
      end
      SeqOpXor: begin
        sum_o  = a_i ^ b_i;
        cout_o = 1'b0;
        half_o = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/gb_cpu_alu_seq.sv
// Multi-cycle slice-serial CPU ALU with valid/ready handshakes on both sides.
// One slice per RUN cycle, LSB first; the result is presented only in DONE.
module gb_cpu_alu_seq
  import gb_cpu_common_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SLICE_W = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  seq_alu_op_t                          op_i,
  input  logic [$clog2(DATA_W/SLICE_W):0]      len_i,
  input  logic [DATA_W-1:0]                    a_i,
  input  logic [DATA_W-1:0]                    b_i,
  input  logic [1:0]                           zmode_i,
  input  alu_flags_t                           flags_i,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_W-1:0]                    result_o,
  output alu_flags_t                           flags_o
);

  localparam int unsigned NSLICE = DATA_W / SLICE_W;
  localparam int unsigned LenW   = $clog2(NSLICE) + 1;

  seq_alu_state_t    state_q, state_d;
  logic              rdy_q;
  seq_alu_op_t       op_q;
  logic [LenW-1:0]   len_q, idx_q, idx_d, len_eff;
  logic [DATA_W-1:0] a_q, b_q;
  logic [1:0]        zmode_q;
  alu_flags_t        flags_in_q;
  logic              carry_q, carry_d;
  logic              zacc_q, zacc_d;
  logic [DATA_W-1:0] result_q, result_d;
  alu_flags_t        flags_q, flags_d, final_flags;

  logic              accept, last;
  logic [31:0]       shamt;
  logic [SLICE_W-1:0] a_sl, b_sl, sl_sum, wr_sl;
  logic              sl_cin, sl_cout, sl_half, is_incdec, z_calc;

  assign accept    = in_valid && in_ready;
  assign in_ready  = rdy_q && (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result_o  = result_q;
  assign flags_o   = flags_q;

  // Length 0 behaves as 1; anything above NSLICE is clamped.
  always_comb begin
    len_eff = len_i;
    if (len_i == '0) begin
      len_eff = LenW'(1);
    end else if (len_i > LenW'(NSLICE)) begin
      len_eff = LenW'(NSLICE);
    end
  end

  // Pick the current slice operands and carry-in.
  assign is_incdec = (op_q == SeqOpInc) || (op_q == SeqOpDec);
  assign shamt     = 32'(idx_q) * SLICE_W;
  assign a_sl      = SLICE_W'(a_q >> shamt);
  assign last      = ((idx_q + LenW'(1)) == len_q);

  always_comb begin
    b_sl   = SLICE_W'(b_q >> shamt);
    sl_cin = carry_q;
    if (is_incdec) begin
      b_sl = (idx_q == '0) ? SLICE_W'(1) : '0;
    end
    if (idx_q == '0) begin
      sl_cin = ((op_q == SeqOpAdc) || (op_q == SeqOpSbc)) ? flags_in_q.c : 1'b0;
    end
  end

  gb_cpu_alu_slice #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .op_i   (op_q),
    .a_i    (a_sl),
    .b_i    (b_sl),
    .cin_i  (sl_cin),
    .sum_o  (sl_sum),
    .cout_o (sl_cout),
    .half_o (sl_half)
  );

  // CP writes A back but still derives Z from the difference.
  assign wr_sl  = (op_q == SeqOpCp) ? a_sl : sl_sum;
  assign z_calc = zacc_q && (sl_sum == '0);

  // Flags as seen after the final slice.
  always_comb begin
    final_flags.n = op_is_sub(op_q);
    final_flags.h = sl_half;
    final_flags.c = is_incdec ? flags_in_q.c : sl_cout;
    case (zmode_q)
      ZmodeKeep: final_flags.z = flags_in_q.z;
      ZmodeZero: final_flags.z = 1'b0;
      default:   final_flags.z = z_calc;
    endcase
    // Wide INC/DEC (register-pair step) leaves every flag untouched.
    if (is_incdec && (len_q > LenW'(1))) begin
      final_flags = flags_in_q;
    end
  end

  // FSM next state and accumulator update.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    zacc_d   = zacc_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StRun;
          idx_d    = '0;
          carry_d  = 1'b0;
          zacc_d   = 1'b1;
          result_d = '0;
        end
      end
      StRun: begin
        result_d = result_q | (DATA_W'(wr_sl) << shamt);
        carry_d  = sl_cout;
        zacc_d   = z_calc;
        idx_d    = idx_q + LenW'(1);
        if (last) begin
          state_d = StDone;
          flags_d = final_flags;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and accumulator state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rdy_q    <= 1'b0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= 1'b1;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // Request capture on acceptance; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= SeqOpAdd;
      len_q      <= LenW'(1);
      a_q        <= '0;
      b_q        <= '0;
      zmode_q    <= ZmodeCalc;
      flags_in_q <= '0;
    end else if (accept) begin
      op_q       <= op_i;
      len_q      <= len_eff;
      a_q        <= a_i;
      b_q        <= b_i;
      zmode_q    <= zmode_i;
      flags_in_q <= flags_i;
    end
  end

endmodule

// File: tb/tb_gb_cpu_alu_seq.sv
// Bench for gb_cpu_alu_seq: a 16-bit and a 32-bit instance against a whole-word reference model.
module tb_gb_cpu_alu_seq;
  import gb_cpu_common_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Index 0 drives the 16-bit instance, index 1 the 32-bit instance.
  logic        in_valid_s [2];
  logic        out_ready_s[2];
  seq_alu_op_t op_s       [2];
  logic [2:0]  len_s      [2];
  logic [31:0] a_s        [2];
  logic [31:0] b_s        [2];
  logic [1:0]  zm_s       [2];
  alu_flags_t  fl_s       [2];

  logic        ir0, ir1, ov0, ov1;
  logic [15:0] res16;
  logic [31:0] res32;
  alu_flags_t  fo0, fo1;

  logic        in_ready_w [2];
  logic        out_valid_w[2];
  logic [31:0] res_w      [2];
  alu_flags_t  fo_w       [2];

  assign in_ready_w[0]  = ir0;
  assign in_ready_w[1]  = ir1;
  assign out_valid_w[0] = ov0;
  assign out_valid_w[1] = ov1;
  assign res_w[0]       = {16'h0, res16};
  assign res_w[1]       = res32;
  assign fo_w[0]        = fo0;
  assign fo_w[1]        = fo1;

  gb_cpu_alu_seq #(.DATA_W(16), .SLICE_W(8)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_s[0]),
    .in_ready  (ir0),
    .op_i      (op_s[0]),
    .len_i     (len_s[0][1:0]),
    .a_i       (a_s[0][15:0]),
    .b_i       (b_s[0][15:0]),
    .zmode_i   (zm_s[0]),
    .flags_i   (fl_s[0]),
    .out_valid (ov0),
    .out_ready (out_ready_s[0]),
    .result_o  (res16),
    .flags_o   (fo0)
  );

  gb_cpu_alu_seq #(.DATA_W(32), .SLICE_W(8)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_s[1]),
    .in_ready  (ir1),
    .op_i      (op_s[1]),
    .len_i     (len_s[1]),
    .a_i       (a_s[1]),
    .b_i       (b_s[1]),
    .zmode_i   (zm_s[1]),
    .flags_i   (fl_s[1]),
    .out_valid (ov1),
    .out_ready (out_ready_s[1]),
    .result_o  (res32),
    .flags_o   (fo1)
  );

  // Whole-word reference: treats the active width as one integer.
  function automatic void model(input seq_alu_op_t op, input int unsigned len_in,
                                input int unsigned nslice, input logic [31:0] a_in,
                                input logic [31:0] b_in, input logic [1:0] zm,
                                input alu_flags_t fi, output logic [31:0] r,
                                output alu_flags_t fo, output int unsigned len);
    longint unsigned m, hm, a, b, ci, res;
    logic h, c, n;
    len = (len_in == 0) ? 1 : ((len_in > nslice) ? nslice : len_in);
    m   = (64'd1 << (len * 8)) - 1;
    hm  = (64'd1 << (len * 8 - 4)) - 1;
    a   = a_in & m;
    b   = b_in & m;
    ci  = 0;
    h   = 0;
    c   = 0;
    n   = 0;
    res = 0;
    case (op)
      SeqOpAdd, SeqOpAdc, SeqOpInc: begin
        if (op == SeqOpInc) b = 1;
        if (op == SeqOpAdc) ci = fi.c;
        res = (a + b + ci) & m;
        c   = (a + b + ci) > m;
        h   = ((a & hm) + (b & hm) + ci) > hm;
      end
      SeqOpSub, SeqOpSbc, SeqOpCp, SeqOpDec: begin
        if (op == SeqOpDec) b = 1;
        if (op == SeqOpSbc) ci = fi.c;
        n   = 1;
        res = (a - b - ci) & m;
        c   = a < (b + ci);
        h   = (a & hm) < ((b & hm) + ci);
      end
      SeqOpAnd: begin res = a & b; h = 1; end
      SeqOpOr:  res = a | b;
      SeqOpXor: res = a ^ b;
      default: ;
    endcase
    if (op == SeqOpInc || op == SeqOpDec) c = fi.c;
    fo.z = (zm == 2'd1) ? fi.z : ((zm == 2'd2) ? 1'b0 : (res == 0));
    fo.n = n;
    fo.h = h;
    fo.c = c;
    if ((op == SeqOpInc || op == SeqOpDec) && len > 1) fo = fi;
    r = (op == SeqOpCp) ? 32'(a) : 32'(res);
  endfunction

  // Present one request, scramble inputs after acceptance, wait for out_valid.
  task automatic send(input int s, input seq_alu_op_t op, input logic [2:0] len,
                      input logic [31:0] a, input logic [31:0] b, input logic [1:0] zm,
                      input alu_flags_t fl, output int lat, output bit ok);
    int k;
    ok  = 1;
    lat = -1;
    @(negedge clk);
    op_s[s] = op; len_s[s] = len; a_s[s] = a; b_s[s] = b; zm_s[s] = zm; fl_s[s] = fl;
    in_valid_s[s] = 1'b1;
    k = 0;
    while (!in_ready_w[s] && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready_w[s]) begin
      in_valid_s[s] = 1'b0;
      ok = 0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid_s[s] = 1'b0;
    a_s[s]  = $urandom;
    b_s[s]  = $urandom;
    op_s[s] = seq_alu_op_t'($urandom_range(0, 9));
    len_s[s] = 3'($urandom);
    zm_s[s] = 2'($urandom_range(0, 2));
    fl_s[s] = alu_flags_t'(4'($urandom));
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid_w[s] && k < 40);
    if (!out_valid_w[s]) ok = 0;
    lat = k - 1;
  endtask

  task automatic consume(input int s);
    out_ready_s[s] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_s[s] = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks += 4;
      if (in_ready_w[s] !== 1'b0) begin
        failures++; $display("FAIL reset_in_ready[%0d] got=%b want=0", s, in_ready_w[s]);
      end
      if (out_valid_w[s] !== 1'b0) begin
        failures++; $display("FAIL reset_out_valid[%0d] got=%b want=0", s, out_valid_w[s]);
      end
      if (res_w[s] !== 32'h0) begin
        failures++; $display("FAIL reset_result[%0d] got=%h want=0", s, res_w[s]);
      end
      if (fo_w[s] !== 4'b0000) begin
        failures++; $display("FAIL reset_flags[%0d] got=%b want=0000", s, fo_w[s]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (in_ready_w[s] !== 1'b1) begin
        failures++; $display("FAIL release_in_ready[%0d] got=%b want=1", s, in_ready_w[s]);
      end
    end
  endtask

  typedef struct {
    seq_alu_op_t op;
    logic [2:0]  len;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  zm;
    alu_flags_t  fl;
    logic [31:0] r;
    alu_flags_t  fo;
  } vec_t;

  task automatic test_directed;
    vec_t v[5];
    int lat;
    bit ok;
    v[0] = '{SeqOpAdd, 3'd2, 32'h0FFF, 32'h0001, 2'd1, 4'b1000, 32'h1000, 4'b1010};
    v[1] = '{SeqOpSub, 3'd1, 32'h0010, 32'h0020, 2'd0, 4'b0000, 32'h00F0, 4'b0101};
    v[2] = '{SeqOpSbc, 3'd1, 32'h0000, 32'h0000, 2'd0, 4'b0001, 32'h00FF, 4'b0111};
    v[3] = '{SeqOpInc, 3'd2, 32'hFFFF, 32'h1234, 2'd0, 4'b1010, 32'h0000, 4'b1010};
    v[4] = '{SeqOpDec, 3'd1, 32'h0001, 32'h0077, 2'd0, 4'b0001, 32'h0000, 4'b1101};
    for (int i = 0; i < 5; i++) begin
      send(0, v[i].op, v[i].len, v[i].a, v[i].b, v[i].zm, v[i].fl, lat, ok);
      checks += 3;
      if (!ok || res_w[0] !== v[i].r) begin
        failures++; $display("FAIL directed_result[%0d] got=%h want=%h", i, res_w[0], v[i].r);
      end
      if (!ok || fo_w[0] !== v[i].fo) begin
        failures++; $display("FAIL directed_flags[%0d] got=%b want=%b", i, fo_w[0], v[i].fo);
      end
      if (lat != int'(v[i].len)) begin
        failures++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, v[i].len);
      end
      consume(0);
    end
  endtask

  task automatic test_random(input int s, input int iters);
    seq_alu_op_t op;
    logic [2:0] len;
    logic [31:0] a, b, er;
    logic [1:0] zm;
    alu_flags_t fl, ef;
    int unsigned elen;
    int lat;
    bit ok;
    for (int i = 0; i < iters; i++) begin
      op  = seq_alu_op_t'($urandom_range(0, 9));
      len = 3'((s == 0) ? $urandom_range(0, 3) : $urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      zm  = 2'($urandom_range(0, 2));
      fl  = alu_flags_t'(4'($urandom));
      model(op, len, (s == 0) ? 2 : 4, a, b, zm, fl, er, ef, elen);
      send(s, op, len, a, b, zm, fl, lat, ok);
      checks += 3;
      if (!ok || res_w[s] !== er) begin
        failures++;
        $display("FAIL rand%0d_result op=%s len=%0d a=%h b=%h got=%h want=%h",
                 s, op.name(), len, a, b, res_w[s], er);
      end
      if (!ok || fo_w[s] !== ef) begin
        failures++;
        $display("FAIL rand%0d_flags op=%s len=%0d a=%h b=%h zm=%0d fi=%b got=%b want=%b",
                 s, op.name(), len, a, b, zm, fl, fo_w[s], ef);
      end
      if (lat != int'(elen)) begin
        failures++; $display("FAIL rand%0d_latency got=%0d want=%0d", s, lat, elen);
      end
      consume(s);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] r0, er;
    alu_flags_t f0, ef;
    int unsigned elen;
    int lat, k;
    bit ok;
    send(0, SeqOpAdd, 3'd1, 32'h00F8, 32'h0009, 2'd0, 4'b0000, lat, ok);
    r0 = res_w[0];
    f0 = fo_w[0];
    checks += 2;
    if (!ok || r0 !== 32'h0001) begin
      failures++; $display("FAIL bp_first_result got=%h want=00000001", r0);
    end
    if (f0 !== 4'b0011) begin
      failures++; $display("FAIL bp_first_flags got=%b want=0011", f0);
    end
    // Second request waits while the first result is stalled.
    op_s[0] = SeqOpXor; len_s[0] = 3'd2; a_s[0] = 32'hA5C3; b_s[0] = 32'h0FF0;
    zm_s[0] = 2'd0; fl_s[0] = 4'b0000;
    in_valid_s[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks += 4;
      if (out_valid_w[0] !== 1'b1) begin
        failures++; $display("FAIL bp_hold_valid[%0d] got=%b want=1", i, out_valid_w[0]);
      end
      if (res_w[0] !== r0) begin
        failures++; $display("FAIL bp_hold_result[%0d] got=%h want=%h", i, res_w[0], r0);
      end
      if (fo_w[0] !== f0) begin
        failures++; $display("FAIL bp_hold_flags[%0d] got=%b want=%b", i, fo_w[0], f0);
      end
      if (in_ready_w[0] !== 1'b0) begin
        failures++; $display("FAIL bp_hold_in_ready[%0d] got=%b want=0", i, in_ready_w[0]);
      end
    end
    out_ready_s[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_s[0] = 1'b0;
    checks += 2;
    if (out_valid_w[0] !== 1'b0) begin
      failures++; $display("FAIL bp_after_hs_valid got=%b want=0", out_valid_w[0]);
    end
    if (in_ready_w[0] !== 1'b1) begin
      failures++; $display("FAIL bp_after_hs_in_ready got=%b want=1", in_ready_w[0]);
    end
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    checks++;
    if (in_ready_w[0] !== 1'b0) begin
      failures++; $display("FAIL bp_second_accept in_ready got=%b want=0", in_ready_w[0]);
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid_w[0] && k < 40);
    model(SeqOpXor, 2, 2, 32'hA5C3, 32'h0FF0, 2'd0, 4'b0000, er, ef, elen);
    checks += 3;
    if (!out_valid_w[0] || res_w[0] !== er) begin
      failures++; $display("FAIL bp_second_result got=%h want=%h", res_w[0], er);
    end
    if (fo_w[0] !== ef) begin
      failures++; $display("FAIL bp_second_flags got=%b want=%b", fo_w[0], ef);
    end
    if (k - 1 != int'(elen)) begin
      failures++; $display("FAIL bp_second_latency got=%0d want=%0d", k - 1, elen);
    end
    consume(0);
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] er;
    alu_flags_t ef;
    int unsigned elen;
    int lat;
    bit ok;
    @(negedge clk);
    checks++;
    if (in_ready_w[0] !== 1'b1) begin
      failures++; $display("FAIL midrst_idle_in_ready got=%b want=1", in_ready_w[0]);
    end
    op_s[0] = SeqOpAdd; len_s[0] = 3'd2; a_s[0] = 32'h1234; b_s[0] = 32'h1111;
    zm_s[0] = 2'd0; fl_s[0] = 4'b1111;
    in_valid_s[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (out_valid_w[0] !== 1'b0) begin
      failures++; $display("FAIL midrst_valid got=%b want=0", out_valid_w[0]);
    end
    if (res_w[0] !== 32'h0) begin
      failures++; $display("FAIL midrst_result got=%h want=0", res_w[0]);
    end
    if (fo_w[0] !== 4'b0000) begin
      failures++; $display("FAIL midrst_flags got=%b want=0000", fo_w[0]);
    end
    if (in_ready_w[0] !== 1'b0) begin
      failures++; $display("FAIL midrst_in_ready got=%b want=0", in_ready_w[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks += 2;
    if (in_ready_w[0] !== 1'b1) begin
      failures++; $display("FAIL midrst_release_in_ready got=%b want=1", in_ready_w[0]);
    end
    if (out_valid_w[0] !== 1'b0) begin
      failures++; $display("FAIL midrst_release_valid got=%b want=0", out_valid_w[0]);
    end
    model(SeqOpSbc, 2, 2, 32'h0100, 32'h0001, 2'd0, 4'b0001, er, ef, elen);
    send(0, SeqOpSbc, 3'd2, 32'h0100, 32'h0001, 2'd0, 4'b0001, lat, ok);
    checks += 2;
    if (!ok || res_w[0] !== er) begin
      failures++; $display("FAIL midrst_recover_result got=%h want=%h", res_w[0], er);
    end
    if (fo_w[0] !== ef) begin
      failures++; $display("FAIL midrst_recover_flags got=%b want=%b", fo_w[0], ef);
    end
    consume(0);
  endtask

  task automatic test_wide32;
    int lat;
    bit ok;
    send(1, SeqOpAdc, 3'd4, 32'hFFFF_FFFF, 32'h0, 2'd0, 4'b0001, lat, ok);
    checks += 3;
    if (!ok || res_w[1] !== 32'h0) begin
      failures++; $display("FAIL wide_adc_result got=%h want=00000000", res_w[1]);
    end
    if (fo_w[1] !== 4'b1011) begin
      failures++; $display("FAIL wide_adc_flags got=%b want=1011", fo_w[1]);
    end
    if (lat != 4) begin
      failures++; $display("FAIL wide_adc_latency got=%0d want=4", lat);
    end
    consume(1);
    // Length 0 runs a single slice and zeroes the upper bytes.
    send(1, SeqOpOr, 3'd0, 32'h1234_5678, 32'h0000_0100, 2'd0, 4'b1111, lat, ok);
    checks += 3;
    if (!ok || res_w[1] !== 32'h0000_0078) begin
      failures++; $display("FAIL wide_len0_result got=%h want=00000078", res_w[1]);
    end
    if (fo_w[1] !== 4'b0000) begin
      failures++; $display("FAIL wide_len0_flags got=%b want=0000", fo_w[1]);
    end
    if (lat != 1) begin
      failures++; $display("FAIL wide_len0_latency got=%0d want=1", lat);
    end
    consume(1);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      in_valid_s[s] = 1'b0; out_ready_s[s] = 1'b0; op_s[s] = SeqOpAdd; len_s[s] = 3'd1;
      a_s[s] = '0; b_s[s] = '0; zm_s[s] = 2'd0; fl_s[s] = '0;
    end
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_wide32();
    test_random(0, 150);
    test_random(1, 150);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
